// File: rtl/fifo1c_rd_stream_if.sv
// FIFO read port plus outgoing valid/ready stream of the fifo1c read drain engine.
// The master side is the drain engine; the slave side is the FIFO/consumer environment.
interface fifo1c_rd_stream_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] fifo_q;
    logic                  fifo_empty;
    logic                  fifo_underflow;
    logic                  fifo_rdreq;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        input  fifo_q,
        input  fifo_empty,
        input  fifo_underflow,
        input  out_ready,
        output fifo_rdreq,
        output out_valid,
        output out_data
    );

    modport slave (
        output fifo_q,
        output fifo_empty,
        output fifo_underflow,
        output out_ready,
        input  fifo_rdreq,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/fifo1c_rd_stream.sv
// Read-side drain engine for a non-show-ahead single-clock FIFO with fixed read latency.
// Requests are only issued when a buffer slot is guaranteed for the returning word, so the
// output buffer can never overrun and full throughput is kept while the consumer is ready.
module fifo1c_rd_stream #(
    parameter int DATA_WIDTH = 64,
    parameter int RD_LAT     = 2,
    parameter int OBUF_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fifo1c_rd_stream_if.master            bus,
    input  logic                          rd_en,
    input  logic                          flush,
    output logic [$clog2(OBUF_DEPTH):0]   obuf_level,
    output logic [CNT_WIDTH-1:0]          out_cnt,
    input  logic                          cnt_clr,
    output logic                          rd_err
);
    localparam int LVL_W = $clog2(OBUF_DEPTH) + 1;
    localparam int PTR_W = $clog2(OBUF_DEPTH);
    localparam logic [LVL_W:0]   DEPTH_V  = (LVL_W + 1)'(OBUF_DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(OBUF_DEPTH);

    logic [RD_LAT-1:0]     lat_sr;
    logic [LVL_W-1:0]      inflight;
    logic [LVL_W-1:0]      level;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] mem [OBUF_DEPTH];
    logic                  rdreq;
    logic                  ret;
    logic                  push;
    logic                  pop;
    logic                  overrun;

    // Issue rule, buffer push/pop qualification and overrun detection
    always_comb begin
        inflight = LVL_W'($countones(lat_sr));
        ret      = lat_sr[RD_LAT-1];
        rdreq    = rst_n && rd_en && !bus.fifo_empty && !flush &&
                   (({1'b0, level} + {1'b0, inflight}) < DEPTH_V);
        pop      = (level != '0) && bus.out_ready && !flush;
        overrun  = ret && !flush && (level == FULL_LVL);
        push     = ret && !flush && !(overrun && !pop);
    end

    assign bus.fifo_rdreq = rdreq;
    assign bus.out_valid  = (level != '0);
    assign bus.out_data   = mem[rd_ptr];
    assign obuf_level     = level;

    generate
        if (RD_LAT == 1) begin : g_lat1
            // Single-stage in-flight tracker; flush forgets the outstanding request
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lat_sr <= '0;
                end else if (flush) begin
                    lat_sr <= '0;
                end else begin
                    lat_sr <= rdreq;
                end
            end
        end else begin : g_latn
            // Multi-stage in-flight tracker; flush forgets all outstanding requests
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lat_sr <= '0;
                end else if (flush) begin
                    lat_sr <= '0;
                end else begin
                    lat_sr <= {lat_sr[RD_LAT-2:0], rdreq};
                end
            end
        end
    endgenerate

    // Capture returning FIFO words into the output buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (push) begin
            mem[wr_ptr] <= bus.fifo_q;
        end
    end

    // Buffer pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Delivered-word counter, wrapping; a clear still counts a coincident pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else if (cnt_clr) begin
            out_cnt <= {{(CNT_WIDTH-1){1'b0}}, pop};
        end else if (pop) begin
            out_cnt <= out_cnt + 1'b1;
        end
    end

    // Sticky error flag for FIFO underflow or a return arriving at a full buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_err <= 1'b0;
        end else if (bus.fifo_underflow || overrun) begin
            rd_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo1c_rd_stream.sv
// Bench for fifo1c_rd_stream: an external FIFO with fixed read latency plus a queue-based
// reference model of the drain engine (buffered words, outstanding reads, counter, error).
module tb_fifo1c_rd_stream;
    localparam int DW     = 64;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;
    localparam int CW     = 4;
    localparam int unsigned CNT_MASK = (1 << CW) - 1;

    typedef struct {
        logic [DW-1:0] w;
        int            age;
        bit            live;
    } pend_t;

    logic                       clk;
    logic                       rst_n;
    logic                       rd_en;
    logic                       flush;
    logic                       cnt_clr;
    logic [$clog2(DEPTH):0]     obuf_level;
    logic [CW-1:0]              out_cnt;
    logic                       rd_err;

    fifo1c_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

    fifo1c_rd_stream #(
        .DATA_WIDTH(DW),
        .RD_LAT    (RD_LAT),
        .OBUF_DEPTH(DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .rd_en     (rd_en),
        .flush     (flush),
        .obuf_level(obuf_level),
        .out_cnt   (out_cnt),
        .cnt_clr   (cnt_clr),
        .rd_err    (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_mem [$];
    pend_t         pend [$];
    logic [DW-1:0] obq [$];
    int unsigned   m_cnt;
    bit            m_err;

    int cyc = 0;
    int rq_pulses, first_req, last_req, first_val, pops, last_pop, max_gap;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        rq_pulses = 0;
        first_req = -1;
        last_req  = -1;
        first_val = -1;
        pops      = 0;
        last_pop  = -1;
        max_gap   = 0;
    endtask

    task automatic model_clear();
        obq.delete();
        foreach (pend[i]) pend[i].live = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic drive_fifo_pins();
        bus.fifo_empty = (fifo_mem.size() == 0);
        bus.fifo_q     = {$urandom, $urandom};
        foreach (pend[i]) if (pend[i].age == 0) bus.fifo_q = pend[i].w;
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_mem.push_back(base + DW'(i));
        drive_fifo_pins();
    endtask

    // One clock: compare at the falling edge, advance model and FIFO after the rising edge
    task automatic tick();
        int            live;
        bit            exp_rq, rq_seen, pop, dpop, cap;
        logic [DW-1:0] cap_w;
        pend_t         keep [$];
        pend_t         e;
        @(negedge clk);
        if (!rst_n) model_clear();
        live = 0;
        foreach (pend[i]) if (pend[i].live) live++;
        exp_rq = rst_n && rd_en && (fifo_mem.size() != 0) && !flush &&
                 ((obq.size() + live) < DEPTH);
        check("rdreq", bus.fifo_rdreq, exp_rq);
        check("out_valid", bus.out_valid, obq.size() != 0);
        check("obuf_level", obuf_level, obq.size());
        check("out_cnt", out_cnt, m_cnt);
        check("rd_err", rd_err, m_err);
        if (obq.size() != 0) check("out_data", bus.out_data, obq[0]);
        check("rdreq_while_empty", bus.fifo_rdreq && (fifo_mem.size() == 0), 0);

        rq_seen = bus.fifo_rdreq;
        pop     = rst_n && (obq.size() != 0) && bus.out_ready && !flush;
        dpop    = rst_n && bus.out_valid && bus.out_ready && !flush;
        if (rq_seen) begin
            rq_pulses++;
            if (first_req < 0) first_req = cyc;
            last_req = cyc;
        end
        if (bus.out_valid && first_val < 0) first_val = cyc;
        if (dpop) begin
            if (last_pop >= 0 && (cyc - last_pop - 1) > max_gap) max_gap = cyc - last_pop - 1;
            last_pop = cyc;
            pops++;
        end

        cap   = 1'b0;
        cap_w = '0;
        foreach (pend[i]) begin
            if (pend[i].age == 0 && pend[i].live && !flush && rst_n) begin
                cap   = 1'b1;
                cap_w = pend[i].w;
            end
        end
        if (rst_n) begin
            if (pop) void'(obq.pop_front());
            if (cap) obq.push_back(cap_w);
            if (flush) begin
                obq.delete();
                foreach (pend[i]) pend[i].live = 1'b0;
            end
            if (cnt_clr) m_cnt = pop ? 1 : 0;
            else         m_cnt = (m_cnt + (pop ? 1 : 0)) & CNT_MASK;
            if (bus.fifo_underflow) m_err = 1'b1;
        end

        @(posedge clk);
        #1;
        foreach (pend[i]) begin
            if (pend[i].age > 0) begin
                e = pend[i];
                e.age--;
                keep.push_back(e);
            end
        end
        pend = keep;
        if (rq_seen && fifo_mem.size() != 0) begin
            e.w    = fifo_mem.pop_front();
            e.age  = RD_LAT - 1;
            e.live = 1'b1;
            pend.push_back(e);
        end
        drive_fifo_pins();
        cyc++;
    endtask

    task automatic run_until_pops(input int target, input int budget, input string tag);
        int n = 0;
        while (pops < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, pops, target);
    endtask

    task automatic wait_level(input int lvl, input int budget, input string tag);
        int n = 0;
        while (obuf_level != lvl && n < budget) begin
            tick();
            n++;
        end
        check(tag, obuf_level, lvl);
    endtask

    int unsigned cnt_before;

    initial begin
        rst_n              = 1'b0;
        rd_en              = 1'b0;
        flush              = 1'b0;
        cnt_clr            = 1'b0;
        bus.out_ready      = 1'b0;
        bus.fifo_underflow = 1'b0;
        model_clear();
        clear_stats();
        drive_fifo_pins();

        repeat (2) tick();
        check("reset_out_data", bus.out_data, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Streaming at full rate
        rd_en = 1'b1;
        bus.out_ready = 1'b1;
        clear_stats();
        push_words(0, 10);
        run_until_pops(10, 40, "stream_pops");
        check("stream_req_pulses", rq_pulses, 10);
        check("stream_req_span", last_req - first_req, 9);
        check("stream_first_valid", first_val - first_req, RD_LAT + 1);
        check("stream_gap", max_gap, 0);
        check("stream_cnt", out_cnt, 10);
        check("stream_err", rd_err, 0);
        repeat (3) tick();

        // Backpressure
        bus.out_ready = 1'b0;
        clear_stats();
        push_words(100, 10);
        repeat (12) tick();
        check("bp_req_pulses", rq_pulses, 4);
        check("bp_level", obuf_level, 4);
        bus.out_ready = 1'b1;
        clear_stats();
        run_until_pops(10, 60, "bp_pops");
        check("bp_gap_ok", max_gap <= RD_LAT, 1);
        repeat (3) tick();

        // Single word in the FIFO
        clear_stats();
        push_words(200, 1);
        repeat (10) tick();
        check("empty_req_pulses", rq_pulses, 1);
        check("empty_pops", pops, 1);
        check("empty_rdreq_after", bus.fifo_rdreq, 0);

        // Flush with two buffered words and one read outstanding
        bus.out_ready = 1'b0;
        push_words(300, 2);
        wait_level(2, 12, "flush_setup_level");
        push_words(302, 2);
        clear_stats();
        tick();
        check("flush_pre_req", rq_pulses, 1);
        flush = 1'b1;
        cnt_before = m_cnt;
        tick();
        flush = 1'b0;
        check("flush_valid", bus.out_valid, 0);
        check("flush_level", obuf_level, 0);
        check("flush_cnt", out_cnt, cnt_before);
        bus.out_ready = 1'b1;
        clear_stats();
        run_until_pops(1, 20, "flush_resume_pop");
        repeat (6) tick();
        check("flush_resume_total", pops, 1);

        // Counter wrap and clear-with-pop
        bus.out_ready = 1'b0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt_cleared", out_cnt, 0);
        bus.out_ready = 1'b1;
        clear_stats();
        push_words(400, 15);
        run_until_pops(15, 50, "cnt_pops15");
        check("cnt_15", out_cnt, 15);
        push_words(415, 1);
        run_until_pops(16, 20, "cnt_pops16");
        check("cnt_wrap", out_cnt, 0);
        bus.out_ready = 1'b0;
        push_words(416, 1);
        wait_level(1, 10, "cnt_setup_level");
        cnt_clr = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt_clr_with_pop", out_cnt, 1);
        repeat (2) tick();

        // Asynchronous reset with words buffered and in flight
        bus.out_ready = 1'b0;
        push_words(500, 8);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rdreq", bus.fifo_rdreq, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_data", bus.out_data, 0);
        check("arst_level", obuf_level, 0);
        check("arst_cnt", out_cnt, 0);
        check("arst_err", rd_err, 0);
        model_clear();
        repeat (2) tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        clear_stats();
        run_until_pops(4, 30, "arst_resume_pops");
        bus.fifo_underflow = 1'b1;
        tick();
        bus.fifo_underflow = 1'b0;
        check("underflow_sets_err", rd_err, 1);
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rd_en         = ($urandom_range(0, 9) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 31) == 0);
            cnt_clr       = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 1) == 1) push_words({$urandom, $urandom}, 1);
            tick();
        end
        rd_en = 1'b1;
        bus.out_ready = 1'b1;
        flush = 1'b0;
        cnt_clr = 1'b0;
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
